// File: rtl/key_event_queue_pkg.sv
// Shared key definitions for the matrix-keyboard event path.
// Provides key widths and lowest-set-bit helpers.
package key_event_queue_pkg;

  localparam int NUM_KEYS   = 16;
  localparam int KEY_CODE_W = 4;

  typedef logic [NUM_KEYS-1:0]   key_mask_t;
  typedef logic [KEY_CODE_W-1:0] key_code_t;

  // Scanning downwards leaves the lowest set index as the final assignment
  function automatic key_code_t lsb_index(input key_mask_t v);
    key_code_t idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = key_code_t'(i);
    end
    return idx;
  endfunction

  function automatic key_mask_t lsb_onehot(input key_mask_t v);
    return v & (~v + key_mask_t'(1));
  endfunction

endpackage

// File: rtl/key_event_queue_sync_fifo.sv
// Generic single-clock FIFO with registered storage and combinational head read.
// Callers must not write when full without a read, nor read when empty.
module sync_fifo #(
  parameter int W     = 4,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign rd_data = mem[rd_ptr];
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);

  // Storage is cleared on reset so the head reads zero while the queue is empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/key_event_queue.sv
// Turns one-clock key press pulses into 4-bit key codes queued for a valid/ready consumer.
// Same-cycle presses wait in a pending mask and drain lowest index first.
module key_event_queue
  import key_event_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_KEYS-1:0]   key_pulse,
  input  logic                  key_ready,
  input  logic                  ovf_clr,
  output logic                  key_valid,
  output logic [KEY_CODE_W-1:0] key_code,
  output logic [AW:0]           fifo_count,
  output logic                  overflow
);

  key_mask_t pend;
  key_mask_t grant;
  key_mask_t pend_n;
  logic      pop;
  logic      wr;
  logic      loss;
  logic      full;
  logic      empty;

  assign key_valid = ~empty;
  assign pop       = key_valid & key_ready;
  // A pop frees a slot this same edge, so a full queue can still accept a write
  assign wr        = (|pend) & (~full | pop);
  assign grant     = wr ? lsb_onehot(pend) : '0;
  assign pend_n    = (pend & ~grant) | key_pulse;
  // A pulse on its own just-granted bit is re-queued, not lost
  assign loss      = |(key_pulse & pend & ~grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend     <= '0;
      overflow <= 1'b0;
    end else begin
      pend <= pend_n;
      if (loss)         overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

  sync_fifo #(
    .W     (KEY_CODE_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr),
    .wr_data (lsb_index(pend)),
    .rd_en   (pop),
    .rd_data (key_code),
    .count   (fifo_count),
    .full    (full),
    .empty   (empty)
  );

endmodule

// File: tb/tb_key_event_queue.sv
// Self-checking bench for key_event_queue: directed scenarios then random traffic,
// checked against a queue-based model of the press/pending/overflow rules.
module tb_key_event_queue;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          rst_n;
  logic [15:0]   key_pulse;
  logic          key_ready;
  logic          ovf_clr;
  logic          key_valid;
  logic [3:0]    key_code;
  logic [AW:0]   fifo_count;
  logic          overflow;

  int tests_run;
  int fails;

  // Reference model: queue of codes, per-key pending flags, sticky loss flag
  int m_q[$];
  bit m_pend[16];
  bit m_ovf;

  key_event_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_pulse  (key_pulse),
    .key_ready  (key_ready),
    .ovf_clr    (ovf_clr),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic modelReset();
    m_q.delete();
    for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
    m_ovf = 1'b0;
  endtask

  task automatic modelStep(input logic [15:0] pulse, input logic ready, input logic clr);
    bit pop;
    bit any;
    bit wr;
    bit loss;
    int code;
    pop  = (m_q.size() != 0) && ready;
    any  = 1'b0;
    code = 0;
    for (int i = 0; i < 16; i++) begin
      if (!any && m_pend[i]) begin
        any  = 1'b1;
        code = i;
      end
    end
    wr = any && ((m_q.size() < DEPTH) || pop);
    if (pop) void'(m_q.pop_front());
    if (wr) begin
      m_q.push_back(code);
      m_pend[code] = 1'b0;
    end
    loss = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pulse[i]) begin
        if (m_pend[i]) loss = 1'b1;
        m_pend[i] = 1'b1;
      end
    end
    if (loss)     m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
  endtask

  task automatic checkValue(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic exp_valid;
    exp_valid = (m_q.size() != 0);
    checkValue({tag, " valid"}, 16'(key_valid), 16'(exp_valid));
    if (exp_valid) checkValue({tag, " code"}, 16'(key_code), 16'(m_q[0]));
    checkValue({tag, " count"}, 16'(fifo_count), 16'(m_q.size()));
    checkValue({tag, " overflow"}, 16'(overflow), 16'(m_ovf));
  endtask

  // Drive inputs away from the edge, advance one edge, update model, check after settling
  task automatic applyStimulus(input logic [15:0] pulse, input logic ready, input logic clr, input string tag);
    key_pulse = pulse;
    key_ready = ready;
    ovf_clr   = clr;
    @(posedge clk);
    modelStep(pulse, ready, clr);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    logic [15:0] rp;
    tests_run = 0;
    fails     = 0;
    modelReset();
    rst_n     = 1'b0;
    key_pulse = '0;
    key_ready = 1'b0;
    ovf_clr   = 1'b0;
    #3;
    checkOutput("reset");
    checkValue("reset code", 16'(key_code), 16'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1: single press, two-edge latency
    applyStimulus(16'h0020, 1'b0, 1'b0, "t1 pulse");
    checkValue("t1 not yet valid", 16'(key_valid), 16'h0);
    applyStimulus(16'h0000, 1'b0, 1'b0, "t1 write");
    checkValue("t1 code", 16'(key_code), 16'h5);
    checkValue("t1 count", 16'(fifo_count), 16'h1);
    applyStimulus(16'h0000, 1'b1, 1'b0, "t1 drain");

    // 2: simultaneous presses serialised lowest first
    applyStimulus(16'h8401, 1'b1, 1'b0, "t2 pulse");
    applyStimulus(16'h0000, 1'b1, 1'b0, "t2 c0");
    checkValue("t2 first", 16'(key_code), 16'h0);
    applyStimulus(16'h0000, 1'b1, 1'b0, "t2 c10");
    checkValue("t2 second", 16'(key_code), 16'hA);
    applyStimulus(16'h0000, 1'b1, 1'b0, "t2 c15");
    checkValue("t2 third", 16'(key_code), 16'hF);
    applyStimulus(16'h0000, 1'b1, 1'b0, "t2 empty");
    checkValue("t2 valid low", 16'(key_valid), 16'h0);

    // 3: fill with keys 0..9, back-pressure holds the last two in pend
    for (int k = 0; k < 10; k++) begin
      applyStimulus(16'h1 << k, 1'b0, 1'b0, "t3 fill");
      applyStimulus(16'h0000, 1'b0, 1'b0, "t3 gap");
    end
    checkValue("t3 count", 16'(fifo_count), 16'h8);
    checkValue("t3 pend", dut.pend, 16'h0300);
    checkValue("t3 overflow", 16'(overflow), 16'h0);
    for (int k = 0; k < 10; k++) begin
      checkValue("t3 order", 16'(key_code), 16'(k));
      applyStimulus(16'h0000, 1'b1, 1'b0, "t3 drain");
    end
    checkValue("t3 drained", 16'(key_valid), 16'h0);

    // 4: overflow on a duplicate pending press, sticky until cleared
    for (int k = 0; k < 8; k++) applyStimulus(16'h1 << k, 1'b0, 1'b0, "t4 fill");
    applyStimulus(16'h0000, 1'b0, 1'b0, "t4 fill last");
    applyStimulus(16'h0008, 1'b0, 1'b0, "t4 pend3");
    checkValue("t4 no loss yet", 16'(overflow), 16'h0);
    applyStimulus(16'h0008, 1'b0, 1'b0, "t4 dup");
    checkValue("t4 overflow set", 16'(overflow), 16'h1);
    applyStimulus(16'h0000, 1'b0, 1'b0, "t4 hold");
    checkValue("t4 overflow holds", 16'(overflow), 16'h1);
    applyStimulus(16'h0000, 1'b0, 1'b1, "t4 clr");
    checkValue("t4 overflow cleared", 16'(overflow), 16'h0);
    applyStimulus(16'h0008, 1'b0, 1'b1, "t4 clr vs loss");
    checkValue("t4 loss wins", 16'(overflow), 16'h1);
    applyStimulus(16'h0000, 1'b0, 1'b1, "t4 clr2");

    // 5: push and pop while full
    applyStimulus(16'h0000, 1'b1, 1'b0, "t5 push pop");
    checkValue("t5 count", 16'(fifo_count), 16'h8);
    checkValue("t5 head", 16'(key_code), 16'h1);

    // 6: asynchronous reset with count=5 and a pending press
    for (int k = 0; k < 3; k++) applyStimulus(16'h0000, 1'b1, 1'b0, "t6 drain");
    applyStimulus(16'h1000, 1'b0, 1'b0, "t6 pend");
    checkValue("t6 pre count", 16'(fifo_count), 16'h5);
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("t6 reset");
    checkValue("t6 reset code", 16'(key_code), 16'h0);
    checkValue("t6 reset pend", dut.pend, 16'h0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    applyStimulus(16'h0000, 1'b0, 1'b0, "t6 after");
    applyStimulus(16'h0000, 1'b1, 1'b0, "t6 after2");

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      rp = '0;
      if ($urandom_range(0, 2) == 0) rp = 16'h1 << $urandom_range(0, 15);
      if ($urandom_range(0, 5) == 0) rp = rp | (16'h1 << $urandom_range(0, 15));
      applyStimulus(rp, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
